// File: rtl/reg_file_sb.sv
// Register file r0..r31 with per-register pending-write counters and a decode stall.
// Optional same-cycle writeback forwarding is enabled by defining REGFILE_BYPASS_EN.
module reg_file_sb #(
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WB_Write,
    input  logic [4:0]  WB_Addr,
    input  logic [31:0] WB_Data,
    input  logic [4:0]  rd_addr_a,
    input  logic [4:0]  rd_addr_b,
    input  logic        rd_use_a,
    input  logic        rd_use_b,
    output logic [31:0] rd_data_a,
    output logic [31:0] rd_data_b,
    input  logic        issue_valid,
    input  logic [4:0]  issue_addr,
    output logic        issue_ready,
    output logic        stall,
    output logic        sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [31:0]      data_rd [32];
    logic [CNT_W-1:0] cnt_rd  [32];
    logic             wb_en;
    logic             issue_acc;
    logic             err_next;
    logic             sb_err_reg;
    logic [4:0]       port_addr [2];
    logic [31:0]      port_data [2];
    logic [1:0]       port_pend;

    // r0 is a hard zero with no storage and no pending state
    assign data_rd[0] = '0;
    assign cnt_rd[0]  = '0;

    assign wb_en       = WB_Write && (WB_Addr != 5'd0);
    assign issue_ready = (issue_addr == 5'd0) || (cnt_rd[issue_addr] != CNT_MAX);
    assign issue_acc   = issue_valid && issue_ready && (issue_addr != 5'd0);

    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_reg
            logic [31:0]      data_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             inc;
            logic             dec;

            assign inc = issue_acc && (issue_addr == 5'(gi));
            assign dec = wb_en && (WB_Addr == 5'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_reg <= '0;
                    cnt_reg  <= '0;
                end else begin
                    if (dec) begin
                        data_reg <= WB_Data;
                    end
                    // simultaneous issue and writeback cancel out; an empty counter never wraps
                    if (inc && !dec) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end else if (dec && !inc && (cnt_reg != '0)) begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
            end

            assign data_rd[gi] = data_reg;
            assign cnt_rd[gi]  = cnt_reg;
        end
    endgenerate

    assign err_next = (issue_valid && !issue_ready) ||
                      (wb_en && (cnt_rd[WB_Addr] == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_err_reg <= 1'b0;
        end else if (err_next) begin
            sb_err_reg <= 1'b1;
        end
    end

    assign sb_err = sb_err_reg;

    assign port_addr[0] = rd_addr_a;
    assign port_addr[1] = rd_addr_b;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic [31:0]      data_p;
            logic             pend_p;
            logic [CNT_W-1:0] cnt_p;

            assign cnt_p = cnt_rd[port_addr[gi]];

            always_comb begin
                data_p = data_rd[port_addr[gi]];
                pend_p = (cnt_p != '0);
`ifdef REGFILE_BYPASS_EN
                // forward the in-flight writeback; its last outstanding write retires now
                if (wb_en && (WB_Addr == port_addr[gi])) begin
                    data_p = WB_Data;
                    if ((cnt_p == CNT_W'(1)) && !(issue_acc && (issue_addr == port_addr[gi]))) begin
                        pend_p = 1'b0;
                    end
                end
`endif
            end

            assign port_data[gi] = data_p;
            assign port_pend[gi] = pend_p;
        end
    endgenerate

    assign rd_data_a = port_data[0];
    assign rd_data_b = port_data[1];
    assign stall     = (rd_use_a && port_pend[0]) || (rd_use_b && port_pend[1]);

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: stimulus pushes expected outputs, a negedge monitor checks them.
module tb_reg_file_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_Write;
    logic [4:0]  WB_Addr;
    logic [31:0] WB_Data;
    logic [4:0]  rd_addr_a, rd_addr_b;
    logic        rd_use_a, rd_use_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic        issue_ready, stall, sb_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        st;
        logic        rdy;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    reg_file_sb #(.CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .WB_Write(WB_Write), .WB_Addr(WB_Addr), .WB_Data(WB_Data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_use_a(rd_use_a), .rd_use_b(rd_use_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .issue_ready(issue_ready), .stall(stall), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s got=%h want=%h", nm, f, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.name, "rd_data_a", rd_data_a, e.a);
            chk(e.name, "rd_data_b", rd_data_b, e.b);
            chk(e.name, "stall", 32'(stall), 32'(e.st));
            chk(e.name, "issue_ready", 32'(issue_ready), 32'(e.rdy));
            chk(e.name, "sb_err", 32'(sb_err), 32'(e.err));
            $display("txn %-10s a=%h b=%h stall=%b rdy=%b err=%b", e.name,
                     rd_data_a, rd_data_b, stall, issue_ready, sb_err);
        end
    end

    // Drive one cycle of inputs just after the rising edge, queue its expected outputs.
    task automatic cyc(input string nm, input logic r,
                       input logic ww, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb,
                       input logic ua, input logic ub,
                       input logic iv, input logic [4:0] ia,
                       input logic [31:0] ea, input logic [31:0] eb,
                       input logic es, input logic er, input logic ee);
        exp_t e;
        rst = r; WB_Write = ww; WB_Addr = wa; WB_Data = wd;
        rd_addr_a = ra; rd_addr_b = rb; rd_use_a = ua; rd_use_b = ub;
        issue_valid = iv; issue_addr = ia;
        e.name = nm; e.a = ea; e.b = eb; e.st = es; e.rdy = er; e.err = ee;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; WB_Write = 1'b0; WB_Addr = '0; WB_Data = '0;
        rd_addr_a = '0; rd_addr_b = '0; rd_use_a = 1'b0; rd_use_b = 1'b0;
        issue_valid = 1'b0; issue_addr = '0;
        @(posedge clk);
        #1;

        //   name         rst ww wa  wd            ra rb ua ub iv ia  exp_a         exp_b  st rdy err
        cyc("rst_held",   1, 0, 0,  0,            3, 7, 1, 1, 1, 5,  0,            0,     0, 1, 0);
        for (int i = 0; i < 32; i++)
            cyc("read_all",0, 0, 0,  0,            5'(i), 5'(31-i), 1, 1, 0, 0, 0, 0,    0, 1, 0);

        cyc("r5_issue",   0, 0, 0,  0,            0, 0, 0, 0, 1, 5,  0,            0,     0, 1, 0);
        cyc("r5_pend",    0, 0, 0,  0,            5, 0, 1, 0, 0, 0,  0,            0,     1, 1, 0);
        cyc("r5_wb",      0, 1, 5,  32'hDEADBEEF, 5, 0, 1, 0, 0, 0,
            BYP ? 32'hDEADBEEF : 32'h0, 0, !BYP, 1, 0);
        cyc("r5_after",   0, 0, 0,  0,            5, 0, 1, 0, 0, 0,  32'hDEADBEEF, 0,     0, 1, 0);

        cyc("r0_wb_iss",  0, 1, 0,  32'hFFFFFFFF, 0, 0, 1, 1, 1, 0,  0,            0,     0, 1, 0);
        cyc("r0_after",   0, 0, 0,  0,            0, 5, 1, 1, 0, 0,  0,            32'hDEADBEEF, 0, 1, 0);

        cyc("r9_issue",   0, 0, 0,  0,            0, 0, 0, 0, 1, 9,  0,            0,     0, 1, 0);
        cyc("r9_iss_wb",  0, 1, 9,  32'h12345678, 9, 0, 1, 0, 1, 9,
            BYP ? 32'h12345678 : 32'h0, 0, 1, 1, 0);
        cyc("r9_after",   0, 0, 0,  0,            9, 0, 1, 0, 0, 9,  32'h12345678, 0,     1, 1, 0);

        cyc("r7_iss1",    0, 0, 0,  0,            0, 0, 0, 0, 1, 7,  0,            0,     0, 1, 0);
        cyc("r7_iss2",    0, 0, 0,  0,            0, 0, 0, 0, 1, 7,  0,            0,     0, 1, 0);
        cyc("r7_iss3",    0, 0, 0,  0,            0, 0, 0, 0, 1, 7,  0,            0,     0, 1, 0);
        cyc("r7_iss4",    0, 0, 0,  0,            0, 0, 0, 0, 1, 7,  0,            0,     0, 0, 0);
        cyc("r7_full",    0, 0, 0,  0,            7, 0, 1, 0, 0, 7,  0,            0,     1, 0, 1);
        cyc("r7_wb1",     0, 1, 7,  32'h77,       7, 0, 1, 0, 0, 7,
            BYP ? 32'h77 : 32'h0, 0, 1, 0, 1);
        cyc("r7_wb2",     0, 1, 7,  32'h78,       7, 0, 1, 0, 0, 7,
            BYP ? 32'h78 : 32'h77, 0, 1, 1, 1);
        cyc("r7_wb3",     0, 1, 7,  32'h79,       7, 0, 1, 0, 0, 7,
            BYP ? 32'h79 : 32'h78, 0, !BYP, 1, 1);
        cyc("r7_clear",   0, 0, 0,  0,            7, 0, 1, 0, 0, 7,  32'h79,       0,     0, 1, 1);

        cyc("rst_pulse",  1, 0, 0,  0,            7, 5, 1, 1, 0, 0,  0,            0,     0, 1, 0);
        cyc("r3_wb_zero", 0, 1, 3,  32'hA5A5A5A5, 3, 0, 1, 0, 0, 0,
            BYP ? 32'hA5A5A5A5 : 32'h0, 0, 0, 1, 0);
        cyc("r3_after",   0, 0, 0,  0,            3, 0, 1, 0, 0, 0,  32'hA5A5A5A5, 0,     0, 1, 1);

        cyc("rst_pulse2", 1, 0, 0,  0,            3, 0, 1, 0, 0, 0,  0,            0,     0, 1, 0);
        cyc("r1_issue",   0, 0, 0,  0,            0, 0, 0, 0, 1, 1,  0,            0,     0, 1, 0);
        cyc("r1wb_r4iss", 0, 1, 1,  32'h0BADF00D, 0, 0, 0, 0, 1, 4,  0,            0,     0, 1, 0);
        cyc("r6_issue",   0, 0, 0,  0,            1, 4, 0, 1, 1, 6,  32'h0BADF00D, 0,     1, 1, 0);
        cyc("mid_rst",    1, 0, 0,  0,            1, 6, 1, 1, 0, 6,  0,            0,     0, 1, 0);
        cyc("r4_wb_lost", 0, 1, 4,  32'h44,       4, 1, 1, 1, 0, 0,
            BYP ? 32'h44 : 32'h0, 0, 0, 1, 0);
        cyc("r4_after",   0, 0, 0,  0,            4, 6, 1, 1, 0, 0,  32'h44,       0,     0, 1, 1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Register file with a pending-write scoreboard. It is the receiving end of the writeback interface (`WB_Data`/`WB_Write`/`WB_Addr`) of the R/I/J CPU, and serves two combinational read ports to the decode stage. The decode stage marks each issued instruction's destination register as pending. Writeback clears the mark. `stall` tells decode when a source operand is not yet valid.

## Interface
Parameters:
- `CNT_W`, default 2: width of each per-register pending counter. The maximum number of outstanding writes per register is 2^CNT_W−1.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `WB_Write` in 1: writeback enable.
- `WB_Addr` in 5: writeback destination register.
- `WB_Data` in 32: writeback value.
- `rd_addr_a` in 5: read port A address.
- `rd_addr_b` in 5: read port B address.
- `rd_use_a` in 1: decode consumes port A this cycle.
- `rd_use_b` in 1: decode consumes port B this cycle.
- `rd_data_a` out 32: port A data.
- `rd_data_b` out 32: port B data.
- `issue_valid` in 1: decode issues an instruction that will write `issue_addr`.
- `issue_addr` in 5: destination of the issued instruction.
- `issue_ready` out 1: the issue can be accepted.
- `stall` out 1: an in-use operand is pending.
- `sb_err` out 1: sticky protocol-error flag.

## Operation
- Storage is 31 × 32-bit registers, r1..r31.
- r0 always reads 0, is never written and is never pending. Writes and issues to r0 are ignored, with no error.
- Reads are combinational: `rd_data_x = reg[rd_addr_x]`.
- Write: when `WB_Write` is high and `WB_Addr != 0`, `reg[WB_Addr] <= WB_Data`.
- Each register r1..r31 has a pending counter `cnt[r]` of width CNT_W.
- Issue is accepted when `issue_valid && issue_ready`.
- `issue_ready = (issue_addr == 0) || cnt[issue_addr] != max`, where max = 2^CNT_W−1.
- An accepted issue increments `cnt[issue_addr]`.
- A writeback with `WB_Addr != 0` decrements `cnt[WB_Addr]`.
- Issue and writeback to the same register in the same cycle: the counter is unchanged and the data write still occurs.
- Writeback to a register whose counter is 0: the data is written, the counter stays 0 (no wrap) and `sb_err` is set.
- Issue while `issue_ready` is low: not accepted, the counter is unchanged and `sb_err` is set.
- `sb_err` clears only on `rst`.
- `stall = (rd_use_a && pend(rd_addr_a)) || (rd_use_b && pend(rd_addr_b))`, where `pend(r) = (r != 0) && cnt[r] != 0`, subject to the bypass rule below.
- `stall` does not depend on `issue_valid` in the same cycle. Decode must not issue while stalled; this is not checked.

## Timing
- Read latency is 0 cycles (combinational from address).
- A write becomes visible on the read ports the cycle after the `clk` edge that performs it, unless the bypass below is enabled.
- Counter updates take effect after the edge. A register issued at edge N reads as pending from cycle N+1.
- Asynchronous `rst` immediately clears all registers to 0, all counters to 0 and `sb_err` to 0. As a result, `rd_data_a`/`rd_data_b` = 0, `stall` = 0 and `issue_ready` = 1 while reset is held and after its release.
- Reset in the middle of outstanding writes discards all pending state. A later writeback to such a register sets `sb_err`.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - Same-cycle write-to-read forwarding. If `WB_Write && WB_Addr != 0 && rd_addr_x == WB_Addr`, then `rd_data_x = WB_Data`.
  - `pend(r)` also treats `cnt[r] == 1` as not pending when this cycle's writeback targets r and no issue to r is accepted this cycle.
- `REGFILE_BYPASS_EN` undefined:
  - No forwarding; reads return the pre-edge register value.
  - `stall` is evaluated from the pre-edge counters only. A writeback removes the stall one cycle later.

## Test plan
- Reset, then read all 32 addresses on both ports -> every read returns 0, with `stall`=0, `issue_ready`=1 and `sb_err`=0.
- Issue r5; next cycle `rd_addr_a`=5 with `rd_use_a`=1 -> `stall`=1. Writeback r5=0xDEADBEEF -> without bypass, `stall` is 1 in the writeback cycle and 0 after it, and port A reads 0xDEADBEEF. With bypass, `stall`=0 and data 0xDEADBEEF in the writeback cycle.
- Issue r7 three times with CNT_W=2 -> `issue_ready`=0 for r7. A fourth `issue_valid` sets `sb_err`=1. Three writebacks -> `cnt`=0 and `stall` clears.
- Issue r9 and writeback r9=0x12345678 in the same cycle, starting from `cnt`=1 -> `cnt` stays 1 and `stall` stays 1 for r9. The next cycle reads 0x12345678.
- Writeback r0=0xFFFFFFFF and issue r0 -> r0 reads 0, `stall`=0 and `sb_err`=0. Writeback r3 with `cnt`=0 -> r3 is written and `sb_err`=1.
- Issue r4 and r6, then assert `rst` mid-cycle -> all outputs return to their reset values immediately. After release, a writeback to r4 sets `sb_err`=1.
